// File: rtl/alu_issue_pkg.sv
// Shared op-code definitions for the ALU and its issue/retire wrapper.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_SLL = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, subtract, shift-left, unsigned set-less-than.
module alu
  import alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHIFT = 3
) (
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [SHIFT-1:0] shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (alu_op_e'(operation))
      ALU_ADD: result = x + y;
      ALU_SUB: result = x - y;
      ALU_SLL: result = x << shamt;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (x < y)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_pipe_reg.sv
// Valid/ready register slice; accepts whenever empty or being drained this cycle.
module pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Data only moves on a real transfer, so it holds its last value when emptied.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/retire wrapper around an external ALU, with a result
// accumulator usable as the x operand and a retired-operation counter.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT       = 3,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_operation,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  input  logic [SHIFT-1:0]       in_shamt,
  input  logic                   in_use_acc,
  output logic [1:0]             alu_operation,
  output logic [WIDTH-1:0]       alu_x,
  output logic [WIDTH-1:0]       alu_y,
  output logic [SHIFT-1:0]       alu_shamt,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_zero,
  output logic [WIDTH-1:0]       acc,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam int unsigned S1_W = 2 + WIDTH + WIDTH + SHIFT + 1;
  localparam int unsigned S2_W = WIDTH + 1;

  logic [S1_W-1:0] s1_in_data, s1_data;
  logic [S2_W-1:0] s2_in_data, s2_data;
  logic            s1_valid, s2_ready;
  logic [WIDTH-1:0] s1_x;
  logic            s1_use_acc;
  logic            s1_xfer;

  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] op_count_q, op_count_d;

  assign s1_in_data = {in_operation, in_x, in_y, in_shamt, in_use_acc};

  pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  assign {alu_operation, s1_x, alu_y, alu_shamt, s1_use_acc} = s1_data;

  // Accumulator is read live so a command directly behind its producer sees the new value.
  assign alu_x = s1_use_acc ? acc_q : s1_x;

  assign s2_in_data = {alu_result, alu_zero};

  pipe_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_result, out_zero} = s2_data;

  assign s1_xfer = s1_valid && s2_ready;

  always_comb begin
    acc_d      = acc_q;
    op_count_d = op_count_q;
    if (s1_xfer) begin
      acc_d      = alu_result;
      op_count_d = op_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      op_count_q <= '0;
    end else begin
      acc_q      <= acc_d;
      op_count_q <= op_count_d;
    end
  end

  assign acc      = acc_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with the real alu: vector table plus stall/reset/wrap sequences.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [1:0]  in_operation = 2'b00;
  logic [7:0]  in_x = 8'd0, in_y = 8'd0;
  logic [2:0]  in_shamt = 3'd0;
  logic        in_use_acc = 1'b0;
  logic        out_ready = 1'b0;

  logic [1:0]  alu_operation, alu_operation2;
  logic [7:0]  alu_x, alu_y, alu_result, alu_x2, alu_y2, alu_result2;
  logic [2:0]  alu_shamt, alu_shamt2;
  logic        alu_zero, alu_zero2;
  logic        out_valid, out_zero, out_valid2, out_zero2;
  logic [7:0]  out_result, acc, out_result2, acc2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(8), .SHIFT(3), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_operation(in_operation), .in_x(in_x), .in_y(in_y), .in_shamt(in_shamt),
    .in_use_acc(in_use_acc), .alu_operation(alu_operation), .alu_x(alu_x),
    .alu_y(alu_y), .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .acc(acc), .op_count(op_count)
  );

  alu #(.WIDTH(8), .SHIFT(3)) u_alu (
    .operation(alu_operation), .x(alu_x), .y(alu_y), .shamt(alu_shamt),
    .result(alu_result), .zero(alu_zero)
  );

  // Narrow-counter copy driven by the same stimulus, for the wrap check.
  alu_issue #(.WIDTH(8), .SHIFT(3), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_operation(in_operation), .in_x(in_x), .in_y(in_y), .in_shamt(in_shamt),
    .in_use_acc(in_use_acc), .alu_operation(alu_operation2), .alu_x(alu_x2),
    .alu_y(alu_y2), .alu_shamt(alu_shamt2), .alu_result(alu_result2), .alu_zero(alu_zero2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
    .out_zero(out_zero2), .acc(acc2), .op_count(op_count2)
  );

  alu #(.WIDTH(8), .SHIFT(3)) u_alu2 (
    .operation(alu_operation2), .x(alu_x2), .y(alu_y2), .shamt(alu_shamt2),
    .result(alu_result2), .zero(alu_zero2)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] sh;
    logic       ua;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t       vecs [12];
  vec_t       v;
  logic [8:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_retired = 0;
  int         cyc = 0;
  int         first_ret = -1;
  int         last_ret = -1;
  int         ret_mark;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Retirement monitor: each handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [8:0] e;
      n_tests++;
      n_retired++;
      if (first_ret < 0) first_ret = cyc;
      last_ret = cyc;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL retire_unexpected: got result %0d with nothing outstanding", out_result);
      end else begin
        e = exp_q.pop_front();
        if ({out_result, out_zero} !== e) begin
          n_fail++;
          $display("[TB] FAIL retire: got result=%0d zero=%0d expected result=%0d zero=%0d",
                   out_result, out_zero, e[8:1], e[0]);
        end else begin
          $display("[TB] retire result=%0d zero=%0d", out_result, out_zero);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t c);
    int n;
    in_valid = 1'b1;
    in_operation = c.op;
    in_x = c.x;
    in_y = c.y;
    in_shamt = c.sh;
    in_use_acc = c.ua;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL send_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({c.r, c.z});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic mk(input int i, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                    input logic [2:0] sh, input logic ua, input logic [7:0] r, input logic z);
    vecs[i].op = op; vecs[i].x = x; vecs[i].y = y; vecs[i].sh = sh;
    vecs[i].ua = ua; vecs[i].r = r; vecs[i].z = z;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mk(0,  ALU_ADD, 8'd5,    8'd3,    3'd0, 1'b0, 8'd8,    1'b0);
    mk(1,  ALU_SUB, 8'd7,    8'd7,    3'd0, 1'b0, 8'd0,    1'b1);
    mk(2,  ALU_ADD, 8'd1,    8'd2,    3'd0, 1'b0, 8'd3,    1'b0);
    mk(3,  ALU_ADD, 8'd0,    8'd4,    3'd0, 1'b1, 8'd7,    1'b0);
    mk(4,  ALU_SLL, 8'd0,    8'd0,    3'd1, 1'b1, 8'd14,   1'b0);
    mk(5,  ALU_SLT, 8'd3,    8'd9,    3'd0, 1'b0, 8'd1,    1'b0);
    mk(6,  ALU_SLT, 8'd9,    8'd3,    3'd0, 1'b0, 8'd0,    1'b1);
    mk(7,  ALU_SUB, 8'd0,    8'd1,    3'd0, 1'b0, 8'd255,  1'b0);
    mk(8,  ALU_ADD, 8'd200,  8'd100,  3'd0, 1'b0, 8'd44,   1'b0);
    mk(9,  ALU_SLL, 8'h81,   8'd0,    3'd7, 1'b0, 8'h80,   1'b0);
    mk(10, ALU_ADD, 8'h55,   8'h80,   3'd0, 1'b1, 8'd0,    1'b1);
    mk(11, ALU_SUB, 8'h55,   8'd1,    3'd0, 1'b1, 8'd255,  1'b0);

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_acc", {24'd0, acc}, 32'd0);
    check("reset_op_count", {16'd0, op_count}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_alu_x", {24'd0, alu_x}, 32'd0);
    check("reset_out_result", {24'd0, out_result}, 32'd0);

    // Back-to-back table with the sink always ready
    out_ready = 1'b1;
    first_ret = -1;
    for (int i = 0; i < 12; i++) send(vecs[i]);
    step(); step();
    check("table_drained", exp_q.size(), 32'd0);
    check("table_retired", n_retired, 32'd12);
    check("table_no_bubbles", last_ret - first_ret, 32'd11);
    check("table_acc", {24'd0, acc}, 32'd255);
    check("table_op_count", {16'd0, op_count}, 32'd12);
    check("table_out_valid_empty", {31'd0, out_valid}, 32'd0);
    check("table_out_result_held", {24'd0, out_result}, 32'd255);

    // Single-cycle latency: accepted at edge N, visible after edge N+1
    in_valid = 1'b1; in_operation = ALU_ADD; in_x = 8'd10; in_y = 8'd20; in_use_acc = 1'b0;
    exp_q.push_back({8'd30, 1'b0});
    step();
    in_valid = 1'b0;
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_out_result", {24'd0, out_result}, 32'd30);
    check("lat_out_zero", {31'd0, out_zero}, 32'd0);
    check("lat_acc", {24'd0, acc}, 32'd30);
    check("lat_op_count", {16'd0, op_count}, 32'd13);
    step();

    // Stall: two buffered, third refused, everything stable
    ret_mark = n_retired;
    out_ready = 1'b0;
    v = vecs[0]; v.op = ALU_ADD; v.x = 8'd1; v.y = 8'd1; v.ua = 1'b0; v.r = 8'd2; v.z = 1'b0;
    send(v);
    v.x = 8'd99; v.y = 8'd3; v.ua = 1'b1; v.r = 8'd5;
    send(v);
    in_valid = 1'b1; in_operation = ALU_SUB; in_x = 8'd0; in_y = 8'd1; in_use_acc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_result", {24'd0, out_result}, 32'd2);
      check("stall_alu_x", {24'd0, alu_x}, 32'd2);
      check("stall_alu_y", {24'd0, alu_y}, 32'd3);
    end
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    v.op = ALU_SUB; v.x = 8'd0; v.y = 8'd1; v.ua = 1'b1; v.r = 8'd4;
    send(v);
    v.op = ALU_SLL; v.y = 8'd0; v.sh = 3'd2; v.r = 8'd16;
    send(v);
    step(); step(); step();
    check("stall_drained", exp_q.size(), 32'd0);
    check("stall_retired", n_retired - ret_mark, 32'd4);
    check("stall_acc", {24'd0, acc}, 32'd16);

    // Reset with two commands in flight
    out_ready = 1'b0;
    v.op = ALU_ADD; v.x = 8'd9; v.y = 8'd9; v.sh = 3'd0; v.ua = 1'b0; v.r = 8'd18;
    send(v);
    v.x = 8'd1; v.y = 8'd1; v.r = 8'd2;
    send(v);
    ret_mark = n_retired;
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    step(); step(); step();
    check("rst_no_stale", n_retired - ret_mark, 32'd0);

    // Narrow counter wraps: five retirements on a 2-bit counter
    for (int i = 0; i < 5; i++) send(vecs[i]);
    step(); step();
    check("wrap_drained", exp_q.size(), 32'd0);
    check("wrap_op_count_wide", {16'd0, op_count}, 32'd5);
    check("wrap_op_count_narrow", {30'd0, op_count2}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
